// File: rtl/xmul_seq.sv
// ---------------------------------------------------------------------------
// xmul_seq: sequential multi-precision row multiply-accumulate.
//   acc[j]   += lo57(a[j] * b)        j = 0..NLIMB-1
//   acc[j+1] += (a[j] * b) >> 57      j = 0..NLIMB-1
// All products come from an external fixed-latency (2 cycle) multiplier that
// also performs the add with the supplied accumulator operand (in3).
//
// Optional feature macro: XMUL_SEQ_CARRY_EN
//   When defined, a CARRY pass runs after DRAIN and normalises every limb
//   below the top one to 57 bits, pushing the excess into the next limb.
//
// Ports
//   clock, reset            clock, synchronous active-high reset
//   start, b_in             request a row op; b_in captured on acceptance
//   busy, done              busy from first issue through the done cycle
//   a_we/a_addr/a_wdata     write port into the A limb file (NLIMB entries)
//   acc_we/acc_addr/
//     acc_wdata/acc_rdata   accumulator file port (NLIMB+1 entries),
//                           read is combinational
//   mul_req_*               multiplier request (valid/dw/fn/tag)
//   mul_in1/2/3             multiplier operands a[j], b, acc[dest]
//   mul_resp_data/tag       multiplier result, no valid bit
// ---------------------------------------------------------------------------
module xmul_seq #(
    parameter int unsigned NLIMB = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] b_in,
    output logic        busy,
    output logic        done,
    input  logic        a_we,
    input  logic [4:0]  a_addr,
    input  logic [63:0] a_wdata,
    input  logic        acc_we,
    input  logic [4:0]  acc_addr,
    input  logic [63:0] acc_wdata,
    output logic [63:0] acc_rdata,
    output logic        mul_req_valid,
    output logic        mul_req_dw,
    output logic [5:0]  mul_req_fn,
    output logic [4:0]  mul_req_tag,
    output logic [63:0] mul_in1,
    output logic [63:0] mul_in2,
    output logic [63:0] mul_in3,
    input  logic [63:0] mul_resp_data,
    input  logic [4:0]  mul_resp_tag
);

    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 5;
    localparam int unsigned FW   = 6;
    localparam int unsigned NACC = NLIMB + 1;
    localparam int unsigned AIW  = $clog2(NLIMB);
    localparam int unsigned CIW  = $clog2(NACC);

    localparam logic [FW-1:0] FN_LO    = FW'(52);
    localparam logic [FW-1:0] FN_HI    = FW'(53);
    localparam logic [AW-1:0] LAST_IDX = AW'(NLIMB - 1);
    localparam logic [AW-1:0] MAX_ACC  = AW'(NLIMB);

`ifdef XMUL_SEQ_CARRY_EN
    localparam int unsigned   LO_BITS = 57;
    localparam logic [DW-1:0] LO_MASK = (DW'(1) << LO_BITS) - DW'(1);
`endif

    // Legal limb range; also keeps every index inside the 5-bit address space.
    if (NLIMB < 4 || NLIMB > 30) begin : g_nlimb_check
        $error("xmul_seq: NLIMB=%0d outside legal range 4..30", NLIMB);
    end

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LO = 3'd1,
        ST_ISSUE_HI = 3'd2,
        ST_DRAIN    = 3'd3,
`ifdef XMUL_SEQ_CARRY_EN
        ST_CARRY    = 3'd4,
`endif
        ST_DONE     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            busy_d, done_d, valid_d;
    logic [FW-1:0]   fn_d;
    logic [AW-1:0]   tag_d;
    logic [DW-1:0]   b_q;
    logic [1:0]      vld_q;
    logic            idle;

    logic [DW-1:0]   a_mem   [NLIMB];
    logic [DW-1:0]   acc_mem [NACC];

    assign idle = (state_q == ST_IDLE);

    // Next-state / next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE_LO;
                    idx_d   = '0;
                end
            end
            ST_ISSUE_LO: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_ISSUE_HI;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_ISSUE_HI: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            // Two cycles let the last two in-flight results land.
            ST_DRAIN: begin
                if (idx_q == AW'(1)) begin
                    idx_d = '0;
`ifdef XMUL_SEQ_CARRY_EN
                    state_d = ST_CARRY;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
`ifdef XMUL_SEQ_CARRY_EN
            ST_CARRY: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        valid_d = (state_d == ST_ISSUE_LO) || (state_d == ST_ISSUE_HI);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        fn_d    = (state_d == ST_ISSUE_HI) ? FN_HI : FN_LO;
        // Hi half lands one limb above its source.
        tag_d   = (state_d == ST_ISSUE_HI) ? idx_d + AW'(1) : idx_d;
    end

    // State, registered outputs, captured b and the multiplier valid tracker.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mul_req_valid <= 1'b0;
            mul_req_fn    <= '0;
            mul_req_tag   <= '0;
            b_q           <= '0;
            vld_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            busy          <= busy_d;
            done          <= done_d;
            mul_req_valid <= valid_d;
            mul_req_fn    <= fn_d;
            mul_req_tag   <= tag_d;
            if (idle && start) begin
                b_q <= b_in;
            end
            vld_q <= {vld_q[0], mul_req_valid};
        end
    end

    // A limb file: external writes only while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NLIMB); i++) begin
                a_mem[i] <= '0;
            end
        end else if (idle && a_we && (a_addr <= LAST_IDX)) begin
            a_mem[a_addr[AIW-1:0]] <= a_wdata;
        end
    end

`ifdef XMUL_SEQ_CARRY_EN
    logic [AW-1:0]  carry_dst_full;
    logic [CIW-1:0] carry_src, carry_dst;
    logic [DW-1:0]  carry_sum;

    // Ripple of one limb's excess above bit 57 into the next limb.
    assign carry_dst_full = idx_q + AW'(1);
    assign carry_src      = idx_q[CIW-1:0];
    assign carry_dst      = carry_dst_full[CIW-1:0];
    assign carry_sum      = acc_mem[carry_dst] + (acc_mem[carry_src] >> LO_BITS);
`endif

    // Accumulator file: idle-only external writes, multiplier writeback, carry pass.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NACC); i++) begin
                acc_mem[i] <= '0;
            end
        end else begin
            if (idle && acc_we && (acc_addr <= MAX_ACC)) begin
                acc_mem[acc_addr[CIW-1:0]] <= acc_wdata;
            end
            if (vld_q[1] && (mul_resp_tag <= MAX_ACC)) begin
                acc_mem[mul_resp_tag[CIW-1:0]] <= mul_resp_data;
            end
`ifdef XMUL_SEQ_CARRY_EN
            if (state_q == ST_CARRY) begin
                acc_mem[carry_dst] <= carry_sum;
                acc_mem[carry_src] <= acc_mem[carry_src] & LO_MASK;
            end
`endif
        end
    end

    assign acc_rdata  = (acc_addr <= MAX_ACC) ? acc_mem[acc_addr[CIW-1:0]] : '0;
    assign mul_req_dw = 1'b1;
    assign mul_in1    = a_mem[idx_q[AIW-1:0]];
    assign mul_in2    = b_q;
    // No bypass: NLIMB >= 4 puts every hi read after the matching lo writeback.
    assign mul_in3    = acc_mem[mul_req_tag[CIW-1:0]];

endmodule

// File: tb/tb_xmul_seq.sv
// ---------------------------------------------------------------------------
// tb_xmul_seq: directed bench for xmul_seq (NLIMB = 9) with a 2-cycle
// multiply-add model standing in for the external multiplier.
// ---------------------------------------------------------------------------
module tb_xmul_seq;

    localparam int N     = 9;
    localparam int LIMIT = 60;
`ifdef XMUL_SEQ_CARRY_EN
    localparam int DONE_CYC = 3 * N + 3;
`else
    localparam int DONE_CYC = 2 * N + 3;
`endif
    localparam logic [63:0] M57 = (64'd1 << 57) - 64'd1;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] b_in;
    logic        busy, done;
    logic        a_we;
    logic [4:0]  a_addr;
    logic [63:0] a_wdata;
    logic        acc_we;
    logic [4:0]  acc_addr;
    logic [63:0] acc_wdata;
    logic [63:0] acc_rdata;
    logic        mul_req_valid, mul_req_dw;
    logic [5:0]  mul_req_fn;
    logic [4:0]  mul_req_tag;
    logic [63:0] mul_in1, mul_in2, mul_in3;
    logic [63:0] mul_resp_data;
    logic [4:0]  mul_resp_tag;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] tr_tag [64];
    logic [5:0] tr_fn  [64];
    int         tr_n, first_v, last_v;

    always #5 clock = ~clock;

    xmul_seq #(.NLIMB(N)) dut (
        .clock(clock), .reset(reset), .start(start), .b_in(b_in),
        .busy(busy), .done(done),
        .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .acc_rdata(acc_rdata),
        .mul_req_valid(mul_req_valid), .mul_req_dw(mul_req_dw),
        .mul_req_fn(mul_req_fn), .mul_req_tag(mul_req_tag),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_in3(mul_in3),
        .mul_resp_data(mul_resp_data), .mul_resp_tag(mul_resp_tag)
    );

    // Multiplier model: fn 52 -> in3 + lo57(in1*in2), fn 53 -> in3 + (in1*in2)>>57.
    // Garbage is returned for idle slots so stray writebacks show up.
    logic [127:0] prod;
    logic [63:0]  res_lo, res_hi, s1_data;
    logic [4:0]   s1_tag;
    assign prod   = {64'd0, mul_in1} * {64'd0, mul_in2};
    assign res_lo = mul_in3 + {7'd0, prod[56:0]};
    assign res_hi = mul_in3 + prod[120:57];

    always @(posedge clock) begin
        if (mul_req_valid && mul_req_fn == 6'd52) begin
            s1_data <= res_lo;
            s1_tag  <= mul_req_tag;
        end else if (mul_req_valid && mul_req_fn == 6'd53) begin
            s1_data <= res_hi;
            s1_tag  <= mul_req_tag;
        end else begin
            s1_data <= {$urandom, $urandom};
            s1_tag  <= 5'($urandom_range(0, 9));
        end
        mul_resp_data <= s1_data;
        mul_resp_tag  <= s1_tag;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input int i, input logic [63:0] v);
        a_we = 1'b1; a_addr = 5'(i); a_wdata = v;
        @(negedge clock);
        a_we = 1'b0;
    endtask

    task automatic wr_acc(input int i, input logic [63:0] v);
        acc_we = 1'b1; acc_addr = 5'(i); acc_wdata = v;
        @(negedge clock);
        acc_we = 1'b0;
    endtask

    task automatic chk_acc(input int i, input logic [63:0] exp);
        acc_addr = 5'(i);
        #1;
        chk($sformatf("acc[%0d]", i), acc_rdata, exp);
    endtask

    task automatic load(input logic [63:0] av);
        for (int i = 0; i < N; i++) wr_a(i, av);
        for (int i = 0; i <= N; i++) wr_acc(i, 64'd0);
    endtask

    // Launch one op; optionally write acc[0] in the start cycle, and optionally
    // pulse start+acc_we in cycle k+inj. Records the request trace and checks timing.
    task automatic run_op(input logic [63:0] b, input int inj,
                          input logic pre_we, input logic [63:0] pre_val);
        int dc;
        dc = -1; tr_n = 0; first_v = -1; last_v = -1;
        start = 1'b1; b_in = b;
        acc_we = pre_we; acc_addr = 5'd0; acc_wdata = pre_val;
        @(negedge clock);
        start = 1'b0; acc_we = 1'b0; b_in = {$urandom, $urandom};
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            if (mul_req_valid) begin
                if (tr_n < 64) begin
                    tr_tag[tr_n] = mul_req_tag;
                    tr_fn[tr_n]  = mul_req_fn;
                end
                tr_n++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (done) begin
                dc = cyc;
                break;
            end
            if (cyc == inj) begin
                start = 1'b1; acc_we = 1'b1; acc_addr = 5'd0; acc_wdata = 64'hDEAD_BEEF;
            end
            @(negedge clock);
            start = 1'b0; acc_we = 1'b0;
        end
        chk("done_cycle", 64'(dc), 64'(DONE_CYC));
        chk("busy_at_done", 64'(busy), 64'd1);
        @(negedge clock);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_pulse_width", 64'(done), 64'd0);
    endtask

    initial begin
        logic any_act;
        reset = 1'b1; start = 1'b0; b_in = '0;
        a_we = 1'b0; a_addr = '0; a_wdata = '0;
        acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(mul_req_valid), 64'd0);
        chk("req_dw", 64'(mul_req_dw), 64'd1);
        chk_acc(0, 64'd0);
        chk_acc(N, 64'd0);

        // a = 1, b = 1: every low limb gets 1, top limb stays 0; plus request trace
        for (int i = 0; i < N; i++) wr_a(i, 64'd1);
        run_op(64'd1, 0, 1'b0, 64'd0);
        chk("valid_count", 64'(tr_n), 64'(2 * N));
        chk("valid_first", 64'(first_v), 64'd1);
        chk("valid_last", 64'(last_v), 64'(2 * N));
        for (int i = 0; i < 2 * N; i++) begin
            chk($sformatf("trace_tag[%0d]", i), 64'(tr_tag[i]),
                (i < N) ? 64'(i) : 64'(i - N + 1));
            chk($sformatf("trace_fn[%0d]", i), 64'(tr_fn[i]),
                (i < N) ? 64'd52 : 64'd53);
        end
        for (int i = 0; i < N; i++) chk_acc(i, 64'd1);
        chk_acc(N, 64'd0);

        // a = b = 2^57-1: lo57 = 1, product >> 57 = 2^57-2
        load(M57);
        run_op(M57, 0, 1'b0, 64'd0);
        chk_acc(0, 64'd1);
        for (int i = 1; i < N; i++) chk_acc(i, M57);
        chk_acc(N, M57 - 64'd1);

        // acc[0] = 2^58+5 written in the start cycle, a = 0, b = 7
        load(64'd0);
        run_op(64'd7, 0, 1'b1, (64'd1 << 58) + 64'd5);
`ifdef XMUL_SEQ_CARRY_EN
        chk_acc(0, 64'd5);
        chk_acc(1, 64'd2);
`else
        chk_acc(0, (64'd1 << 58) + 64'd5);
        chk_acc(1, 64'd0);
`endif
        for (int i = 2; i <= N; i++) chk_acc(i, 64'd0);

        // start + acc_we pulsed in ISSUE_HI (cycle k+12): no restart, no port write
        load(64'd1);
        run_op(64'd3, 12, 1'b0, 64'd0);
        for (int i = 0; i < N; i++) chk_acc(i, 64'd3);
        chk_acc(N, 64'd0);

        // Reset in cycle k+12 aborts and clears everything
        start = 1'b1; b_in = 64'd1;
        @(negedge clock);
        start = 1'b0;
        repeat (11) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(mul_req_valid), 64'd0);
        any_act = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            any_act = any_act | busy | done | mul_req_valid;
        end
        chk("abort_quiet", 64'(any_act), 64'd0);
        for (int i = 0; i <= N; i++) chk_acc(i, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xmul_seq.md
XMUL_SEQ -- requirements
Module: xmul_seq

Interface
REQ-001 NLIMB, 9, limb count of the multi-precision operand; legal range 4..30, elaboration error outside it.
REQ-002 Clock and reset are one clock `clock`, reset `reset`, synchronous active-high; all state updates on rising edge of `clock`.
REQ-003 clock  in  1  system clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 start  in  1  request one row operation; sampled only in IDLE.
REQ-006 b_in  in  64  scalar multiplier limb, captured when start accepted.
REQ-007 busy  out  1  high from cycle after accepted start until done cycle inclusive.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 a_we / a_addr / a_wdata  in  1/5/64  write port to internal A limb file, NLIMB entries.
REQ-010 acc_we / acc_addr / acc_wdata  in  1/5/64  write port to internal accumulator file, NLIMB+1 entries.
REQ-011 acc_rdata  out  64  combinational read of accumulator entry acc_addr.
REQ-012 mul_req_valid, mul_req_dw, mul_req_fn[5:0], mul_req_tag[4:0]  out  issue to multiplier; dw constant 1.
REQ-013 mul_in1, mul_in2, mul_in3  out  64 each  multiplier operands.
REQ-014 mul_resp_data  in  64, mul_resp_tag  in  5  multiplier result; no valid bit supplied.

Function
REQ-015 Operation: acc[j] += lo57(a[j]*b) for j=0..NLIMB-1, then acc[j+1] += hi(a[j]*b) >> 57 for j=0..NLIMB-1, all mod 2^64.
REQ-016 Lo issues use fn=52 (madd57lu), hi issues fn=53 (madd57hu); in1=a[j], in2=captured b, in3=current acc of destination; tag = destination index.
REQ-017 States IDLE, ISSUE_LO, ISSUE_HI, DRAIN, CARRY (macro only), DONE.
REQ-018 start sampled high in IDLE at edge k: ISSUE_LO cycles k+1..k+NLIMB (j=0..NLIMB-1), ISSUE_HI cycles k+NLIMB+1..k+2NLIMB (dest j+1), DRAIN cycles k+2NLIMB+1..k+2NLIMB+2.
REQ-019 mul_req_valid high exactly in ISSUE_LO/ISSUE_HI cycles, one request per cycle, no bubbles.
REQ-020 Multiplier latency fixed at 2: result for request issued in cycle c is on mul_resp_data during c+2; block tracks it with a 2-stage valid shift register.
REQ-021 Writeback: when tracked valid at stage 2, acc[mul_resp_tag] <= mul_resp_data at end of that cycle.
REQ-022 Without CARRY, done=1 in cycle k+2NLIMB+3, then IDLE; busy low from k+2NLIMB+4.
REQ-023 NLIMB>=4 guarantees each ISSUE_HI read of acc[j+1] follows the ISSUE_LO writeback of that entry; no bypass logic.
REQ-024 start while not IDLE ignored; a_we/acc_we while busy ignored; acc_rdata valid at all times.
REQ-025 External write in the same cycle start is accepted takes effect before first issue.

Reset
REQ-026 Reset: state IDLE, busy=0, done=0, mul_req_valid=0, valid pipe cleared, captured b=0, A and accumulator files cleared to 0.
REQ-027 Reset mid-operation aborts: mul_req_valid=0 from next cycle, in-flight results never written back.

Configuration
REQ-028 Macro XMUL_SEQ_CARRY_EN: when defined, after DRAIN the CARRY state runs NLIMB cycles, j=0..NLIMB-1 ascending: acc[j+1] += acc[j]>>57, acc[j] &= 2^57-1; done in cycle k+3NLIMB+3.
REQ-029 Without XMUL_SEQ_CARRY_EN, CARRY state and its adder absent; timing per REQ-022.

Verification
REQ-030 NLIMB=9, a[j]=1, b=1, acc=0 -> acc[0..8]=1, acc[9]=0, done at k+21 (k+30 with carry).
REQ-031 a[j]=2^57-1, b=2^57-1, acc=0 -> acc[0]=1, acc[1..8]=2^57-1, acc[9]=2^57-2.
REQ-032 Carry build: acc[0]=2^58+5, others 0, a=0, b=7 -> acc[0]=5, acc[1]=2, rest 0.
REQ-033 Tag/fn trace: tags 0..8 with fn=52 then 1..9 with fn=53, mul_req_valid high exactly 18 consecutive cycles.
REQ-034 start and acc_we=1 pulsed during ISSUE_HI -> no restart, accumulator unchanged by port.
REQ-035 reset asserted in cycle k+12 -> busy=0, mul_req_valid=0 next cycle, all acc entries 0, no later writes.
